// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NREQ requesters.
// Define ARB_PKT_LOCK_EN to hold a grant for a whole packet until its tail beat.
//
// state | meaning
// ARB   | arbitrate every cycle, round-robin starting after rr_ptr
// HOLD  | packet in progress, grant locked to owner until tail beat
module fifo_wr_arbiter #(
   parameter int NREQ  = 4,
   parameter int DSIZE = 32
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_last,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       grant,
   output logic                  busy,
   output logic [DSIZE-1:0]      wdata,
   output logic                  winc,
   input  logic                  wfull
);

   localparam int IDXW = $clog2(NREQ);

   typedef enum logic {ARB, HOLD} state_t;

   state_t          fsm;
   logic [IDXW-1:0] owner;
   logic [IDXW-1:0] rr_ptr;

   logic            arb_hit;
   logic [IDXW-1:0] arb_idx;
   logic            sel_hit;
   logic [IDXW-1:0] sel_idx;

   // Search rr_ptr+1, rr_ptr+2, ... wrapping modulo NREQ; first valid wins.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         logic [IDXW:0] sum;
         sum = {1'b0, rr_ptr} + (IDXW+1)'(k);
         if (sum >= (IDXW+1)'(NREQ))
            sum = sum - (IDXW+1)'(NREQ);
         if (!arb_hit && req_valid[sum[IDXW-1:0]]) begin
            arb_hit = 1'b1;
            arb_idx = sum[IDXW-1:0];
         end
      end
   end

   assign sel_hit = (fsm == HOLD) ? 1'b1  : arb_hit;
   assign sel_idx = (fsm == HOLD) ? owner : arb_idx;

   always_comb begin
      grant = '0;
      for (int i = 0; i < NREQ; i++)
         grant[i] = wrst_n && sel_hit && (sel_idx == IDXW'(i));
   end

   always_comb begin
      wdata = '0;
      for (int i = 0; i < NREQ; i++)
         if (grant[i])
            wdata = req_data[i*DSIZE +: DSIZE];
   end

   assign winc      = (|(grant & req_valid)) & ~wfull;
   assign req_ready = grant & {NREQ{winc}};
   assign busy      = wrst_n && (fsm == HOLD);

`ifdef ARB_PKT_LOCK_EN
   logic sel_last;
   assign sel_last = |(grant & req_last);
`else
   logic unused_last;
   assign unused_last = ^req_last;
`endif

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         fsm    <= ARB;
         owner  <= '0;
         rr_ptr <= IDXW'(NREQ-1);
      end else if (winc) begin
`ifdef ARB_PKT_LOCK_EN
         if (fsm == ARB) begin
            if (sel_last) begin
               rr_ptr <= sel_idx;
            end else begin
               fsm   <= HOLD;
               owner <= sel_idx;
            end
         end else if (sel_last) begin
            fsm    <= ARB;
            rr_ptr <= owner;
         end
`else
         rr_ptr <= sel_idx;
`endif
      end
   end

endmodule
